cambio_dispensador: RTL and testbench
=====================================

CAMBIO_DISPENSADOR -- requirements
Module: cambio_dispensador

Interface
REQ-001 Parameter PULSE_CYCLES, default 2, clock cycles a coin-eject output is held high (legal range 1..15).
REQ-002 Parameter GAP_CYCLES, default 2, idle clock cycles between consecutive coin ejects (legal range 1..15).
REQ-003 clk  input  1  single system clock, all logic rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to pay out change, one-cycle pulse.
REQ-006 amount  input  8  change to pay, unsigned, units of 100 colones.
REQ-007 empty500  input  1  high when the 500-coin hopper is exhausted.
REQ-008 empty100  input  1  high when the 100-coin hopper is exhausted.
REQ-009 coin500  output  1  eject one 500 coin while high.
REQ-010 coin100  output  1  eject one 100 coin while high.
REQ-011 busy  output  1  high in every state except IDLE, DONE and FAULT.
REQ-012 done  output  1  one-cycle pulse when payout completes.
REQ-013 fault  output  1  high while payout cannot be completed.
REQ-014 remaining  output  8  change still owed, units of 100.

Function
REQ-015 States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
REQ-016 IDLE: start=1 latches amount into remaining and moves to SELECT on the same edge; start is ignored in all other states.
REQ-017 SELECT, evaluated in priority order:
- remaining==0 -> DONE.
- remaining>=5 and empty500==0 -> PULSE with coin500 chosen.
- empty100==0 -> PULSE with coin100 chosen.
- otherwise -> FAULT.
REQ-018 empty500 and empty100 are sampled only in SELECT; changes during PULSE or GAP do not affect the coin in flight.
REQ-019 PULSE: the chosen coin output is high for exactly PULSE_CYCLES consecutive cycles; coin500 and coin100 are never high together.
REQ-020 On the PULSE exit edge, remaining decrements by 5 (500 coin) or 1 (100 coin), then the FSM enters GAP.
REQ-021 GAP: both coin outputs low for exactly GAP_CYCLES cycles, then SELECT.
REQ-022 DONE: done=1 for one cycle, then IDLE; done is asserted 2 cycles after the start edge when amount==0.
REQ-023 FAULT: fault=1, coin outputs low, remaining holds the unpaid amount; the FSM leaves FAULT only on rst.
REQ-024 Cycles per coin = 1 (SELECT) + PULSE_CYCLES + GAP_CYCLES.
REQ-025 remaining never underflows; subtract 5 is selected only when remaining>=5.
REQ-026 Greedy order: all possible 500 coins are paid first; when the 500 hopper is empty, the remainder is paid in 100 coins.

Reset
REQ-027 rst forces IDLE; coin500, coin100, busy, done and fault = 0; remaining = 0; timer = 0.
REQ-028 rst mid-PULSE drops the coin output on the next edge and abandons the payout without a done pulse.
REQ-029 rst has priority over start in the same cycle.

Structure
REQ-030 Shared package cambio_pkg holds the state enum, COIN500_UNITS=5, COIN100_UNITS=1, and the PULSE_CYCLES/GAP_CYCLES defaults.
REQ-031 One sub-module, timer_pulso: a 4-bit loadable down-counter with a zero flag, reused for both PULSE and GAP timing.
REQ-032 The FSM is a single registered-state process; all outputs are registered or decoded purely from the state.

Verification
REQ-033 amount=7, no hoppers empty, P=G=2: coin500 x1 then coin100 x2; remaining steps 7->2->1->0; done at cycle 2+3*5 after start.
REQ-034 amount=0: no coin pulses; done high exactly 2 cycles after start; busy high 1 cycle.
REQ-035 amount=6, empty500=1: six coin100 pulses and no coin500; done asserted.
REQ-036 amount=3, empty100 rises during the 2nd GAP: third SELECT -> FAULT; remaining=1; fault stays high; start ignored.
REQ-037 amount=10, rst during the 1st coin500 pulse: coin500=0 and remaining=0 next cycle; no done pulse; a new start with amount=1 pays one coin100.
REQ-038 start pulsed while busy with amount=11 (first payout amount=5): the second request is ignored and exactly one coin500 is paid.

Source files
------------

// File: rtl/cambio_pkg.sv
// cambio_pkg: shared states, coin weights and timing defaults for the change dispenser
package cambio_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE, FAULT} estado_t;
  localparam logic [7:0] COIN500_UNITS = 8'd5;
  localparam logic [7:0] COIN100_UNITS = 8'd1;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int GAP_CYCLES_DEF = 2;
endpackage

// File: rtl/timer_pulso.sv
// timer_pulso: 4-bit loadable down-counter with zero flag
module timer_pulso (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  output logic       zero
);
  logic [3:0] count;
  always_ff @(posedge clk)
    count <= rst ? 4'd0 : load ? value : (count != 4'd0) ? count - 4'd1 : count;
  assign zero = count == 4'd0;
endmodule

// File: rtl/cambio_dispensador.sv
// cambio_dispensador: greedy 500/100 coin change payout FSM with timed eject pulses
module cambio_dispensador
  import cambio_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       empty500,
  input  logic       empty100,
  output logic       coin500,
  output logic       coin100,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining
);
  estado_t    state;
  logic       sel500;
  logic       t_load;
  logic [3:0] t_val;
  logic       t_zero;
  // timer holds N-1 so the state lasts exactly N cycles
  always_comb begin
    t_load = (state == SELECT) || (state == PULSE && t_zero);
    t_val  = (state == SELECT) ? 4'(PULSE_CYCLES - 1) : 4'(GAP_CYCLES - 1);
  end
  timer_pulso u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .value(t_val),
    .zero (t_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel500    <= 1'b0;
      remaining <= 8'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          remaining <= amount;
          state     <= SELECT;
        end
        SELECT: if (remaining == 8'd0) state <= DONE;
          else if (remaining >= COIN500_UNITS && !empty500) begin
            sel500 <= 1'b1;
            state  <= PULSE;
          end else if (!empty100) begin
            sel500 <= 1'b0;
            state  <= PULSE;
          end else state <= FAULT;
        PULSE: if (t_zero) begin
          remaining <= remaining - (sel500 ? COIN500_UNITS : COIN100_UNITS);
          state     <= GAP;
        end
        GAP: if (t_zero) state <= SELECT;
        DONE: state <= IDLE;
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
  assign coin500 = state == PULSE && sel500;
  assign coin100 = state == PULSE && !sel500;
  assign busy    = state == SELECT || state == PULSE || state == GAP;
  assign done    = state == DONE;
  assign fault   = state == FAULT;
endmodule

// File: tb/tb_cambio_dispensador.sv
// tb_cambio_dispensador: directed checks of payout sequencing, faults and reset
module tb_cambio_dispensador;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, empty500 = 1'b0, empty100 = 1'b0;
  logic [7:0] amount = 8'd0;
  logic coin500, coin100, busy, done, fault;
  logic [7:0] remaining;
  int nchk = 0, nfail = 0;
  int k, n500, n100, c500, c100, nboth, ndone, nbusy, done_k, first500_k;
  int rem [0:63];
  logic p500, p100;
  cambio_dispensador dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .empty500(empty500), .empty100(empty100),
    .coin500(coin500), .coin100(coin100), .busy(busy), .done(done),
    .fault(fault), .remaining(remaining)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (coin500 && !p500) n500++;
    if (coin100 && !p100) n100++;
    if (coin500 && first500_k < 0) first500_k = k;
    c500 += int'(coin500);
    c100 += int'(coin100);
    nboth += int'(coin500 && coin100);
    ndone += int'(done);
    nbusy += int'(busy);
    if (done && done_k < 0) done_k = k;
    if (k < 64) rem[k] = int'(remaining);
    p500 = coin500;
    p100 = coin100;
  endtask
  task automatic clr();
    k = 0; n500 = 0; n100 = 0; c500 = 0; c100 = 0; nboth = 0;
    ndone = 0; nbusy = 0; done_k = -1; first500_k = -1; p500 = 0; p100 = 0;
  endtask
  task automatic begin_pay(input logic [7:0] a);
    start = 1'b1;
    amount = a;
    clr();
    step();
    start = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    clr();
    do_reset();
    chk("rst_coins", int'(coin500) + int'(coin100), 0);
    chk("rst_flags", int'(busy) + int'(done) + int'(fault), 0);
    chk("rst_remaining", int'(remaining), 0);
    // 7 -> one 500 then two 100
    begin_pay(8'd7);
    chk("a7_busy_select", int'(busy), 1);
    while (k < 21) step();
    chk("a7_done_k", done_k, 17);
    chk("a7_first500_k", first500_k, 2);
    chk("a7_n500", n500, 1);
    chk("a7_n100", n100, 2);
    chk("a7_c500", c500, 2);
    chk("a7_c100", c100, 4);
    chk("a7_ndone", ndone, 1);
    chk("a7_overlap", nboth, 0);
    chk("a7_rem1", rem[1], 7);
    chk("a7_rem4", rem[4], 2);
    chk("a7_rem9", rem[9], 1);
    chk("a7_rem14", rem[14], 0);
    chk("a7_idle_busy", int'(busy), 0);
    // zero amount
    begin_pay(8'd0);
    while (k < 6) step();
    chk("a0_done_k", done_k, 2);
    chk("a0_nbusy", nbusy, 1);
    chk("a0_coins", n500 + n100, 0);
    chk("a0_ndone", ndone, 1);
    // 500 hopper empty
    empty500 = 1'b1;
    begin_pay(8'd6);
    while (k < 36) step();
    chk("a6_n100", n100, 6);
    chk("a6_n500", n500, 0);
    chk("a6_c100", c100, 12);
    chk("a6_done_k", done_k, 32);
    chk("a6_ndone", ndone, 1);
    empty500 = 1'b0;
    // 100 hopper runs out during second gap
    begin_pay(8'd3);
    while (k < 9) step();
    empty100 = 1'b1;
    while (k < 14) step();
    chk("a3_fault", int'(fault), 1);
    chk("a3_remaining", int'(remaining), 1);
    chk("a3_busy", int'(busy), 0);
    chk("a3_n100", n100, 2);
    chk("a3_ndone", ndone, 0);
    start = 1'b1;
    amount = 8'd9;
    step();
    start = 1'b0;
    while (k < 20) step();
    chk("a3_fault_hold", int'(fault), 1);
    chk("a3_rem_hold", int'(remaining), 1);
    chk("a3_n100_hold", n100, 2);
    empty100 = 1'b0;
    do_reset();
    chk("a3_fault_clr", int'(fault), 0);
    // reset mid-pulse
    begin_pay(8'd10);
    step();
    chk("a10_coin500_on", int'(coin500), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("a10_coin500_off", int'(coin500), 0);
    chk("a10_rem_zero", int'(remaining), 0);
    while (k < 12) step();
    chk("a10_ndone", ndone, 0);
    chk("a10_n500", n500, 1);
    begin_pay(8'd1);
    while (k < 10) step();
    chk("a1_n100", n100, 1);
    chk("a1_n500", n500, 0);
    chk("a1_done_k", done_k, 7);
    // start while busy is ignored
    begin_pay(8'd5);
    while (k < 3) step();
    start = 1'b1;
    amount = 8'd11;
    step();
    start = 1'b0;
    while (k < 16) step();
    chk("a5_n500", n500, 1);
    chk("a5_n100", n100, 0);
    chk("a5_done_k", done_k, 7);
    chk("a5_ndone", ndone, 1);
    chk("a5_rem", int'(remaining), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
